// File: rtl/uart_data_tx_if.sv
// Handshake and serial-line bundle for the multi-byte UART transmitter.
// The master side supplies words, the slave side (the transmitter) drives the line and status.
interface uart_data_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2:0]            baud_set;
  logic                  send_en;
  logic [DATA_WIDTH-1:0] data;
  logic                  uart_tx;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output baud_set, send_en, data,
    input  uart_tx, busy, tx_done
  );

  modport slave (
    input  baud_set, send_en, data,
    output uart_tx, busy, tx_done
  );
endinterface

// File: rtl/uart_data_tx.sv
// Multi-byte 8N1 UART transmitter: splits a DATA_WIDTH word into bytes and serialises
// each one, with optional idle bit-times between bytes of the same word.
module uart_data_tx #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_BITS   = 0,
  parameter int SIM_DIV    = 0
) (
  input logic           clk,
  input logic           reset,
  uart_data_tx_if.slave bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(NBYTES + 1);
  localparam logic [BYTE_W-1:0] NBYTES_L = BYTE_W'(NBYTES);
  localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [12:0]           div_q;
  logic [12:0]           cnt_q;
  logic [12:0]           cnt_d;
  logic [12:0]           div_sel;
  logic [2:0]            bit_q;
  logic [3:0]            gap_q;
  logic [BYTE_W-1:0]     bytes_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7:0]            cur_byte;
  logic                  bit_end;

  always_comb begin
    div_sel = 13'd434;
    if (SIM_DIV != 0) begin
      div_sel = 13'(SIM_DIV);
    end else begin
      case (bus.baud_set)
        3'd0:    div_sel = 13'd5208;
        3'd1:    div_sel = 13'd2604;
        3'd2:    div_sel = 13'd1302;
        3'd3:    div_sel = 13'd868;
        default: div_sel = 13'd434;
      endcase
    end
  end

  // The byte on the wire always sits at the end of the shift register that leaves first.
  assign cur_byte = MSB_FIRST ? shift_q[DATA_WIDTH-1 -: 8] : shift_q[7:0];
  assign bit_end  = (cnt_q == div_q - 13'd1);
  assign cnt_d    = bit_end ? 13'd0 : cnt_q + 13'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      bytes_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (bus.send_en) begin
            shift_q <= bus.data;
            div_q   <= div_sel;
            bytes_q <= NBYTES_L;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= 3'd0;
            tx_q    <= cur_byte[0];
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
              bytes_q <= bytes_q - BYTE_W'(1);
              shift_q <= MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end
        end
        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bytes_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP_BITS > 0) begin
              state_q <= S_GAP;
              gap_q   <= 4'd0;
            end else begin
              state_q <= S_START;
              tx_q    <= 1'b0;
            end
          end
        end
        S_GAP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (gap_q == GAP_LAST) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              gap_q <= gap_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.uart_tx = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_data_tx.sv
// Bench for uart_data_tx: two 16-bit configurations driven in parallel and checked against
// a bit-list waveform model and a line decoder, plus an 8-bit instance on the real baud table.
module tb_uart_data_tx;
  localparam int DIV   = 4;
  localparam int GAP_B = 2;
  localparam int WMAX  = 511;

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    logic [15:0] word;
    int          done_a;
    int          done_b;
    logic [7:0]  first_a;
    logic [7:0]  first_b;
  } vec_t;

  localparam obs_t O_IDLE = '{line: 1'b1, busy: 1'b0, done: 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_en_s = 1'b0;
  logic [15:0] data_s = 16'h0000;
  always #5 clk = ~clk;

  uart_data_tx_if #(.DATA_WIDTH(16)) ifa ();
  uart_data_tx_if #(.DATA_WIDTH(16)) ifb ();
  uart_data_tx_if #(.DATA_WIDTH(8))  ifc ();

  assign ifa.send_en  = send_en_s;
  assign ifa.data     = data_s;
  assign ifa.baud_set = 3'd0;
  assign ifb.send_en  = send_en_s;
  assign ifb.data     = data_s;
  assign ifb.baud_set = 3'd0;

  uart_data_tx #(.DATA_WIDTH(16), .MSB_FIRST(1'b1), .GAP_BITS(0), .SIM_DIV(DIV))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  uart_data_tx #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .GAP_BITS(GAP_B), .SIM_DIV(DIV))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  uart_data_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .GAP_BITS(0), .SIM_DIV(0))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  int errors = 0;
  int checks = 0;

  obs_t exp_a [0:WMAX];
  obs_t exp_b [0:WMAX];
  obs_t act_a [0:WMAX];
  obs_t act_b [0:WMAX];
  obs_t expm  [0:WMAX];
  int          req_c [0:7];
  logic [15:0] req_w [0:7];
  int          nreq;
  int          rst_c;
  logic [15:0] acc_w [$];
  logic [15:0] acc_a [$];
  logic [15:0] acc_b [$];
  bit          wv [0:255];
  int          wv_len;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic put_bit(input bit v);
    for (int d = 0; d < DIV; d++) begin
      wv[wv_len] = v;
      wv_len++;
    end
  endtask

  // Expected line for one word: the list of 8N1 characters with gap bits, each bit DIV clocks.
  task automatic make_wave(input logic [15:0] w, input bit msb, input int gap);
    logic [7:0] bytes [0:1];
    bytes[0] = msb ? w[15:8] : w[7:0];
    bytes[1] = msb ? w[7:0]  : w[15:8];
    wv_len = 0;
    for (int b = 0; b < 2; b++) begin
      put_bit(1'b0);
      for (int i = 0; i < 8; i++) put_bit(bytes[b][i]);
      put_bit(1'b1);
      if (b == 0) for (int g = 0; g < gap; g++) put_bit(1'b1);
    end
  endtask

  task automatic apply_model_reset(input int len, inout int end_prev);
    for (int e = rst_c; e <= len; e++) expm[e] = O_IDLE;
    if (end_prev >= rst_c) end_prev = rst_c;
  endtask

  task automatic build_model(input bit msb, input int gap, input int len);
    int end_prev;
    bit rst_done;
    int c;
    for (int e = 0; e <= len; e++) expm[e] = O_IDLE;
    end_prev = 0;
    rst_done = 1'b0;
    acc_w.delete();
    for (int q = 0; q < nreq; q++) begin
      c = req_c[q];
      if (rst_c > 0 && !rst_done && c > rst_c) begin
        apply_model_reset(len, end_prev);
        rst_done = 1'b1;
      end
      if (c != rst_c && c > end_prev) begin
        make_wave(req_w[q], msb, gap);
        for (int j = 0; j < wv_len; j++)
          if (c + j <= len) expm[c + j] = '{line: wv[j], busy: 1'b1, done: 1'b0};
        if (c + wv_len <= len) expm[c + wv_len] = '{line: 1'b1, busy: 1'b0, done: 1'b1};
        end_prev = c + wv_len;
        acc_w.push_back(req_w[q]);
      end
    end
    if (rst_c > 0 && !rst_done) apply_model_reset(len, end_prev);
  endtask

  function automatic logic get_line(input bit sel_b, input int e);
    return sel_b ? act_b[e].line : act_a[e].line;
  endfunction

  task automatic compare_window(input string nm, input bit sel_b, input int len);
    int bad;
    int first;
    obs_t a;
    obs_t x;
    bad = 0;
    first = -1;
    for (int e = 1; e <= len; e++) begin
      a = sel_b ? act_b[e] : act_a[e];
      x = sel_b ? exp_b[e] : exp_a[e];
      if (a != x) begin
        if (first < 0) first = e;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      a = sel_b ? act_b[first] : act_a[first];
      x = sel_b ? exp_b[first] : exp_a[first];
      $display("FAIL %s: %0d cycles differ, first at edge %0d line/busy/done got %b expected %b",
               nm, bad, first, a, x);
    end
  endtask

  // Independent receiver: finds start bits, samples mid-bit, reassembles words.
  task automatic decode_check(input string nm, input bit sel_b, input int len);
    logic [7:0]  bq [$];
    logic [7:0]  by;
    logic [15:0] w;
    logic [15:0] expq [$];
    int e;
    int bad;
    logic prev;
    expq = sel_b ? acc_b : acc_a;
    e = 1;
    bad = 0;
    while (e <= len - 10 * DIV) begin
      prev = (e == 1) ? 1'b1 : get_line(sel_b, e - 1);
      if (get_line(sel_b, e) == 1'b0 && prev == 1'b1) begin
        by = 8'h00;
        for (int i = 0; i < 8; i++) by[i] = get_line(sel_b, e + DIV * (1 + i) + DIV / 2);
        if (get_line(sel_b, e + 9 * DIV + DIV / 2) != 1'b1) bad++;
        bq.push_back(by);
        e += 10 * DIV;
      end else begin
        e++;
      end
    end
    if (bq.size() != 2 * expq.size()) bad++;
    for (int k = 0; k < expq.size() && 2 * k + 1 < bq.size(); k++) begin
      w = sel_b ? {bq[2 * k + 1], bq[2 * k]} : {bq[2 * k], bq[2 * k + 1]};
      if (w != expq[k]) bad++;
    end
    check(nm, bad, 0);
  endtask

  task automatic run_window(input string nm, input int len);
    build_model(1'b1, 0, len);
    exp_a = expm;
    acc_a = acc_w;
    build_model(1'b0, GAP_B, len);
    exp_b = expm;
    acc_b = acc_w;
    for (int e = 1; e <= len; e++) begin
      send_en_s = 1'b0;
      for (int q = 0; q < nreq; q++) begin
        if (req_c[q] == e) begin
          send_en_s = 1'b1;
          data_s    = req_w[q];
        end
      end
      reset = (e == rst_c);
      tick();
      act_a[e] = '{line: ifa.uart_tx, busy: ifa.busy, done: ifa.tx_done};
      act_b[e] = '{line: ifb.uart_tx, busy: ifb.busy, done: ifb.tx_done};
    end
    send_en_s = 1'b0;
    reset = 1'b0;
    compare_window({nm, "_wave_a"}, 1'b0, len);
    compare_window({nm, "_wave_b"}, 1'b1, len);
    if (rst_c == 0) begin
      decode_check({nm, "_decode_a"}, 1'b0, len);
      decode_check({nm, "_decode_b"}, 1'b1, len);
    end
    $display("window %s: requests=%0d reset_edge=%0d accepted_a=%0d accepted_b=%0d",
             nm, nreq, rst_c, acc_a.size(), acc_b.size());
  endtask

  function automatic int count_done(input bit sel_b, input int from, input int to);
    int n;
    n = 0;
    for (int e = from; e <= to; e++) n += int'(sel_b ? act_b[e].done : act_a[e].done);
    return n;
  endfunction

  initial begin
    vec_t vt [0:3];
    int   done_a;
    int   done_b;
    int   busy_a;
    int   busy_b;
    logic [7:0] fa;
    logic [7:0] fb;
    int   c;
    int   done_k;
    int   busy_k;
    logic l433;
    logic l434;
    logic l868;

    vt[0] = '{16'hA55A, 80, 88, 8'hA5, 8'h5A};
    vt[1] = '{16'h1234, 80, 88, 8'h12, 8'h34};
    vt[2] = '{16'h8001, 80, 88, 8'h80, 8'h01};
    vt[3] = '{16'h00FF, 80, 88, 8'h00, 8'hFF};

    ifc.send_en  = 1'b0;
    ifc.data     = 8'h00;
    ifc.baud_set = 3'd4;

    reset = 1'b1;
    repeat (3) tick();
    check("reset_a", int'({ifa.uart_tx, ifa.busy, ifa.tx_done}), 3'b100);
    check("reset_b", int'({ifb.uart_tx, ifb.busy, ifb.tx_done}), 3'b100);
    check("reset_c", int'({ifc.uart_tx, ifc.busy, ifc.tx_done}), 3'b100);
    reset = 1'b0;
    tick();

    // Directed single words: hand-derived done edge, busy length and first byte on the wire.
    for (int r = 0; r < 4; r++) begin
      nreq = 1;
      req_c[0] = 1;
      req_w[0] = vt[r].word;
      rst_c = 0;
      run_window($sformatf("vec%0d", r), 100);
      done_a = -1;
      done_b = -1;
      busy_a = 0;
      busy_b = 0;
      for (int e = 100; e >= 1; e--) begin
        if (act_a[e].done) done_a = e - 1;
        if (act_b[e].done) done_b = e - 1;
        busy_a += int'(act_a[e].busy);
        busy_b += int'(act_b[e].busy);
      end
      for (int i = 0; i < 8; i++) begin
        fa[i] = act_a[1 + DIV * (1 + i) + 2].line;
        fb[i] = act_b[1 + DIV * (1 + i) + 2].line;
      end
      check($sformatf("vec%0d_done_a", r), done_a, vt[r].done_a);
      check($sformatf("vec%0d_done_b", r), done_b, vt[r].done_b);
      check($sformatf("vec%0d_busy_a", r), busy_a, vt[r].done_a);
      check($sformatf("vec%0d_busy_b", r), busy_b, vt[r].done_b);
      check($sformatf("vec%0d_first_a", r), int'(fa), int'(vt[r].first_a));
      check($sformatf("vec%0d_first_b", r), int'(fb), int'(vt[r].first_b));
    end

    // send_en while busy is dropped.
    nreq = 2;
    req_c[0] = 1;  req_w[0] = 16'hA55A;
    req_c[1] = 20; req_w[1] = 16'hFFFF;
    rst_c = 0;
    run_window("busy_reject", 120);
    check("busy_reject_done_a", count_done(1'b0, 1, 120), 1);

    // send_en in the tx_done cycle of A starts the next word one edge later.
    nreq = 2;
    req_c[0] = 1;  req_w[0] = 16'hA55A;
    req_c[1] = 82; req_w[1] = 16'h0001;
    rst_c = 0;
    run_window("back2back", 200);
    check("b2b_done_edge_a", int'(act_a[81].done), 1);
    check("b2b_start_a", int'({act_a[82].line, act_a[82].busy}), 2'b01);
    check("b2b_done_b", count_done(1'b1, 1, 200), 1);

    // Reset during the data bits of byte 0 aborts the word; a later word goes out normally.
    nreq = 2;
    req_c[0] = 1;  req_w[0] = 16'h1234;
    req_c[1] = 40; req_w[1] = 16'hBEEF;
    rst_c = 20;
    run_window("reset_mid", 200);
    check("reset_mid_line_busy_a", int'({act_a[20].line, act_a[20].busy}), 2'b10);
    check("reset_mid_no_done_a", count_done(1'b0, 20, 39), 0);
    check("reset_mid_after_done_a", count_done(1'b0, 40, 200), 1);

    // Randomised windows: overlapping requests, occasional reset.
    for (int w = 0; w < 40; w++) begin
      nreq = 1 + int'($urandom % 3);
      c = 0;
      for (int q = 0; q < nreq; q++) begin
        c = c + 1 + int'($urandom_range(0, 60));
        req_c[q] = c;
        req_w[q] = 16'($urandom);
      end
      rst_c = ($urandom % 4 == 0) ? int'($urandom_range(2, 150)) : 0;
      run_window($sformatf("rand%0d", w), 300);
    end

    // Real baud table on the 8-bit instance: 434 clocks per bit, baud_set change mid-frame ignored.
    ifc.baud_set = 3'd4;
    ifc.data     = 8'h55;
    ifc.send_en  = 1'b1;
    tick();
    ifc.send_en = 1'b0;
    check("baud_start_c", int'({ifc.uart_tx, ifc.busy}), 2'b01);
    done_k = -1;
    busy_k = int'(ifc.busy);
    l433 = 1'bx;
    l434 = 1'bx;
    l868 = 1'bx;
    for (int k = 1; k <= 4345; k++) begin
      if (k == 100) begin
        ifc.baud_set = 3'd0;
        ifc.data     = 8'h00;
      end
      tick();
      if (ifc.tx_done && done_k < 0) done_k = k;
      busy_k += int'(ifc.busy);
      if (k == 433) l433 = ifc.uart_tx;
      if (k == 434) l434 = ifc.uart_tx;
      if (k == 868) l868 = ifc.uart_tx;
    end
    check("baud_done_c", done_k, 4340);
    check("baud_busy_c", busy_k, 4340);
    check("baud_start_end_c", int'(l433), 0);
    check("baud_bit0_c", int'(l434), 1);
    check("baud_bit1_c", int'(l868), 0);
    check("baud_idle_c", int'({ifc.uart_tx, ifc.busy, ifc.tx_done}), 3'b100);
    $display("word c: data=55 baud_set=4 done_edge=%0d busy_cycles=%0d", done_k, busy_k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_data_tx.md
# uart_data_tx

Multi-byte UART transmitter: accepts a DATA_WIDTH-bit word on a one-cycle send strobe, splits it into DATA_WIDTH/8 bytes and serialises each as an 8N1 character at the baud selected by `baud_set`. The byte serialiser is built in, so the block has no submodules. It is the transmit-side counterpart of the multi-byte UART receiver and uses the same baud encoding and byte-order convention, so a word sent here is reassembled unchanged by that receiver.

## Interface
- `DATA_WIDTH`, 16: word width in bits; a multiple of 8, minimum 8.
- `MSB_FIRST`, 1: 1 sends `data[DATA_WIDTH-1:DATA_WIDTH-8]` first; 0 sends `data[7:0]` first.
- `GAP_BITS`, 0: idle (high) bit-times inserted between bytes of one word, 0–15; never after the last byte.
- `SIM_DIV`, 0: if nonzero, replaces the `baud_set` divider with this value (clocks per bit), for simulation only.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `baud_set` in 3: 0→5208, 1→2604, 2→1302, 3→868, 4–7→434 clocks per bit (9600/19200/38400/57600/115200 baud).
- `send_en` in 1: one-cycle start strobe; accepted only when `busy`=0.
- `data` in DATA_WIDTH: word to send; sampled in the accept cycle.
- `uart_tx` out 1: serial line, registered, idles high.
- `busy` out 1: a word is in flight.
- `tx_done` out 1: one-cycle pulse when the last stop bit of the word completes.

## Operation
- Accept happens on the edge where `send_en`=1 and `busy`=0. That edge captures `data` into a shift register, captures the divider (from `baud_set` or `SIM_DIV`) and loads the byte counter with DATA_WIDTH/8.
- Later changes to `data` or `baud_set` have no effect until the next accept.
- `send_en` while `busy`=1 is ignored. Nothing is queued and no error is flagged.
- States:
  - IDLE: `uart_tx`=1. On accept, go to START.
  - START: line 0 for one bit-time, then go to DATA.
  - DATA: 8 bits, LSB first, one bit-time each, then go to STOP.
  - STOP: line 1 for one bit-time. Then:
    - if bytes remain and GAP_BITS>0, go to GAP;
    - if bytes remain and GAP_BITS=0, go to START;
    - if no bytes remain, go to IDLE and pulse `tx_done`.
  - GAP: line 1 for GAP_BITS bit-times, then go to START.
- Bit-time counter: runs 0..DIV-1 and wraps on bit advance. It is 13 bits wide.
- Byte advance:
  - MSB_FIRST=1: shift the word left by 8.
  - MSB_FIRST=0: shift the word right by 8.
- DATA_WIDTH=8: a single byte, no gap logic exercised.
- Reset:
  - Reset values: `uart_tx`=1, `busy`=0, `tx_done`=0, state IDLE, all counters 0.
  - Reset asserted mid-word aborts the word: the line is high from the next edge and no `tx_done` is generated.
  - Reset has priority over `send_en` in the same cycle.
- Unknown or illegal state encodings recover to IDLE with `uart_tx`=1.

## Timing
- Accept at edge E0:
  - `busy`=1 and `uart_tx`=0 (start bit) from E0.
  - Each bit occupies exactly DIV cycles.
- Word length T = N·10·DIV + (N−1)·GAP_BITS·DIV cycles, where N = DATA_WIDTH/8.
- At edge E0+T: `uart_tx`=1, `busy`=0, `tx_done`=1 for exactly one cycle.
- Back-to-back words:
  - `send_en` asserted in the `tx_done` cycle is accepted at E0+T+1.
  - The start bit then follows the previous stop bit with exactly 1 extra idle clock, so the minimum idle between words is 1 clock.
- With GAP_BITS=0, bytes within a word are contiguous: the stop bit is immediately followed by the next start bit.
- `tx_done` and `busy` never both read 1 in the same cycle.

## Test plan
- **Single word, MSB first.** SIM_DIV=4, DATA_WIDTH=16, data=16'hA55A, one `send_en` → line carries 0,0x5A-byte-order: start,bits of 8'hA5 LSB first,stop,start,bits of 8'h5A,stop. Each bit is exactly 4 clocks, `tx_done` at E0+80, `busy` high for 80 cycles.
- **Byte order and gap.** MSB_FIRST=0, GAP_BITS=2, data=16'h1234 → 8'h34 first, then 8 clocks high, then 8'h12. `tx_done` at E0+88.
- **Busy rejection and back-to-back.** `send_en` with 16'hFFFF mid-word → ignored, first word unchanged. `send_en` in the `tx_done` cycle with 16'h0001 → accepted, start bit at next edge.
- **Reset mid-word.** Reset during the DATA state of byte 0 → next edge `uart_tx`=1, `busy`=0, no `tx_done`. A fresh `send_en` then transmits normally.
- **Baud table.** SIM_DIV=0, baud_set=4, DATA_WIDTH=8, data=8'h55 → each bit 434 clocks, `tx_done` at E0+4340. baud_set changed mid-frame → no effect on the current frame.
- **Loopback.** Output fed to the multi-byte receiver, same `baud_set`/MSB_FIRST, 200 random 16-bit words → every received word equals the sent word.
